asm_serial_accumulator: RTL



---
 rtl/asm_serial_accumulator_if.sv | 39 +++
 rtl/asm_serial_accumulator.sv | 139 +++++++++++++
 2 files changed

// File: rtl/asm_serial_accumulator_if.sv
// rtl/asm_serial_accumulator_if.sv - operand/result handshake bundle for the ASM serial accumulator
//   master: front end / consumer side (drives operands and out_ready)
//   slave : accumulator side (drives in_ready, out_valid, R, busy)
//   in_valid/in_ready      operand bundle handshake
//   B                      raw multiplier, used for nibble-zero detection
//   I1/I3/I5/I7_wire       alphabet bank 1A, 3A, 5A, 7A
//   SEL_in/SL_in           packed per-nibble alphabet select and left-shift codes
//   out_valid/out_ready    product handshake
//   R                      product
//   busy                   accumulator not idle
interface asm_serial_accumulator_if #(
    parameter int WIDTH             = 32,
    parameter int NIBBLES           = WIDTH / 4,
    parameter int LOG2_NIBBLE_WIDTH = 2
);
    logic                                   in_valid;
    logic                                   in_ready;
    logic [WIDTH-1:0]                       B;
    logic [WIDTH+2:0]                       I1_wire;
    logic [WIDTH+2:0]                       I3_wire;
    logic [WIDTH+2:0]                       I5_wire;
    logic [WIDTH+2:0]                       I7_wire;
    logic [LOG2_NIBBLE_WIDTH*NIBBLES-1:0]   SEL_in;
    logic [LOG2_NIBBLE_WIDTH*NIBBLES-1:0]   SL_in;
    logic                                   out_valid;
    logic                                   out_ready;
    logic [2*WIDTH-1:0]                     R;
    logic                                   busy;

    modport master (
        output in_valid, B, I1_wire, I3_wire, I5_wire, I7_wire, SEL_in, SL_in, out_ready,
        input  in_ready, out_valid, R, busy
    );

    modport slave (
        input  in_valid, B, I1_wire, I3_wire, I5_wire, I7_wire, SEL_in, SL_in, out_ready,
        output in_ready, out_valid, R, busy
    );
endinterface

// File: rtl/asm_serial_accumulator.sv
// rtl/asm_serial_accumulator.sv - ASM back end: nibble-serial select/shift/add product reconstruction
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    asm_serial_accumulator_if.slave (operand in, product out, busy)
// Optional feature macro: ASM_ZERO_SKIP_EN - stop RUN at the highest nonzero B nibble.
module asm_serial_accumulator #(
    parameter int WIDTH             = 32,
    parameter int NIBBLES           = WIDTH / 4,
    parameter int LOG2_NIBBLE_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    asm_serial_accumulator_if.slave   bus
);
    localparam int IDX_W  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int CODE_W = LOG2_NIBBLE_WIDTH * NIBBLES;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state_q;
    logic [IDX_W-1:0]        idx_q;
    logic [2*WIDTH-1:0]      acc_q;
    logic [WIDTH-1:0]        b_q;
    logic [WIDTH+2:0]        i1_q, i3_q, i5_q, i7_q;
    logic [CODE_W-1:0]       sel_q, sl_q;
    logic [2*WIDTH-1:0]      r_q;
    logic                    in_ready_q, out_valid_q, busy_q;

    logic [3:0]                   nib_d;
    logic [LOG2_NIBBLE_WIDTH-1:0] sel_d, sl_d;
    logic [WIDTH+2:0]             op_d;
    logic [2*WIDTH-1:0]           term_d, acc_d;
    logic                         last_d;

`ifdef ASM_ZERO_SKIP_EN
    logic [NIBBLES-1:0]      nzmask_q;
    logic [NIBBLES-1:0]      nzmask_d;
    logic [IDX_W-1:0]        hi_idx_d;

    // hi_idx defaults to 0 so B == 0 finishes after a single (zero) term.
    always_comb begin
        nzmask_d = '0;
        hi_idx_d = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            nzmask_d[i] = |bus.B[4*i +: 4];
            if (nzmask_q[i]) hi_idx_d = IDX_W'(i);
        end
    end
`endif

    always_comb begin
        nib_d = b_q[int'(idx_q)*4 +: 4];
        sel_d = sel_q[int'(idx_q)*LOG2_NIBBLE_WIDTH +: LOG2_NIBBLE_WIDTH];
        sl_d  = sl_q[int'(idx_q)*LOG2_NIBBLE_WIDTH +: LOG2_NIBBLE_WIDTH];
        case (sel_d)
            2'd0:    op_d = i1_q;
            2'd1:    op_d = i3_q;
            2'd2:    op_d = i5_q;
            default: op_d = i7_q;
        endcase
        // Shifts are performed at full 2*WIDTH so overflow wraps mod 2^(2*WIDTH).
        term_d = '0;
        if (nib_d != 4'd0)
            term_d = ({{(WIDTH-3){1'b0}}, op_d} << sl_d) << (4 * int'(idx_q));
        acc_d = acc_q + term_d;
`ifdef ASM_ZERO_SKIP_EN
        last_d = (idx_q == hi_idx_d);
`else
        last_d = (idx_q == IDX_W'(NIBBLES - 1));
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            b_q         <= '0;
            i1_q        <= '0;
            i3_q        <= '0;
            i5_q        <= '0;
            i7_q        <= '0;
            sel_q       <= '0;
            sl_q        <= '0;
            r_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef ASM_ZERO_SKIP_EN
            nzmask_q    <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        b_q        <= bus.B;
                        i1_q       <= bus.I1_wire;
                        i3_q       <= bus.I3_wire;
                        i5_q       <= bus.I5_wire;
                        i7_q       <= bus.I7_wire;
                        sel_q      <= bus.SEL_in;
                        sl_q       <= bus.SL_in;
                        acc_q      <= '0;
                        idx_q      <= '0;
`ifdef ASM_ZERO_SKIP_EN
                        nzmask_q   <= nzmask_d;
`endif
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    idx_q <= idx_q + 1'b1;
                    if (last_d) begin
                        r_q         <= acc_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.R         = r_q;
    assign bus.busy      = busy_q;
endmodule
